// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the lab05 MIPS control path: opcodes, functs, ALU codes,
// mux selects and the multi-cycle state encoding.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  typedef struct packed {
    logic [3:0] aluCtr;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       pcEn;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       illegal;
  } ctrl_t;

  // Every path back to FETCH ends an instruction (normally or by illegal abort).
  function automatic logic retires(state_t cur, state_t nxt);
    return (cur != S_FETCH) && (nxt == S_FETCH);
  endfunction

endpackage

// File: rtl/alu_ctr_decode.sv
// R-type funct to ALU operation decode; combinational, shared with the pipelined core.
module alu_ctr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluCtr,
  output logic       valid
);

  always_comb begin
    aluCtr = ALU_BAD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  aluCtr = ALU_ADD;
      FN_SUB:  aluCtr = ALU_SUB;
      FN_AND:  aluCtr = ALU_AND;
      FN_OR:   aluCtr = ALU_OR;
      FN_SLT:  aluCtr = ALU_SLT;
      FN_NOR:  aluCtr = ALU_NOR;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: Moore outputs per state, beq resolved from the live
// ALU zero flag, and a retired-instruction counter.
module multi_cycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opCode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [3:0]       aluCtr,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic             pcEn,
  output logic [1:0]       pcSource,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regDst,
  output logic             memToReg,
  output logic             regWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] instCount,
  output logic [3:0]       state
);

  state_t     cur, nxt;
  ctrl_t      c;
  logic [3:0] dec_ctr;
  logic       dec_valid;

  alu_ctr_decode u_dec (
    .funct  (funct),
    .aluCtr (dec_ctr),
    .valid  (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= S_FETCH;
      instCount <= '0;
    end else begin
      cur <= nxt;
      if (retires(cur, nxt)) instCount <= instCount + CNT_W'(1);
    end
  end

  always_comb begin
    nxt = cur;
    c   = '0;
    case (cur)
      S_FETCH: begin
        c.memRead = 1'b1;
        c.irWrite = 1'b1;
        c.pcEn    = 1'b1;
        c.aluSrcB = SRCB_FOUR;
        c.aluCtr  = ALU_ADD;
        c.pcSource = PCS_ALU;
        nxt = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        c.aluSrcB = SRCB_IMM_SH2;
        c.aluCtr  = ALU_ADD;
        case (opCode)
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDI_EX;
          default: begin
            c.illegal = 1'b1;
            nxt = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluCtr  = ALU_ADD;
        nxt = (opCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.iorD    = 1'b1;
        c.memRead = 1'b1;
        nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.regWrite = 1'b1;
        c.memToReg = 1'b1;
        nxt = S_FETCH;
      end
      S_MEM_WR: begin
        c.iorD     = 1'b1;
        c.memWrite = 1'b1;
        nxt = S_FETCH;
      end
      S_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_REG;
        c.aluCtr  = dec_ctr;
        if (dec_valid) nxt = S_R_WB;
        else begin
          c.illegal = 1'b1;
          nxt = S_FETCH;
        end
      end
      S_R_WB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluSrcB  = SRCB_REG;
        c.aluCtr   = ALU_SUB;
        c.pcSource = PCS_ALUOUT;
        c.pcEn     = zero;
        nxt = S_FETCH;
      end
      S_JUMP: begin
        c.pcSource = PCS_JUMP;
        c.pcEn     = 1'b1;
        nxt = S_FETCH;
      end
      S_ADDI_EX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluCtr  = ALU_ADD;
        nxt = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        c.regWrite = 1'b1;
        nxt = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so an in-flight instruction cannot commit anything.
  assign pcEn     = c.pcEn     & ~reset;
  assign irWrite  = c.irWrite  & ~reset;
  assign memRead  = c.memRead  & ~reset;
  assign memWrite = c.memWrite & ~reset;
  assign regWrite = c.regWrite & ~reset;
  assign illegal  = c.illegal  & ~reset;

  assign aluCtr   = c.aluCtr;
  assign aluSrcA  = c.aluSrcA;
  assign aluSrcB  = c.aluSrcB;
  assign pcSource = c.pcSource;
  assign iorD     = c.iorD;
  assign regDst   = c.regDst;
  assign memToReg = c.memToReg;
  assign state    = cur;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl (CNT_W=4): per-cycle expected outputs are
// queued as each instruction is issued and popped against the DUT at the falling edge.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode, funct;
  logic       zero;
  logic [3:0] aluCtr, state, instCount;
  logic       aluSrcA, pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, illegal;
  logic [1:0] aluSrcB, pcSource;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct), .zero(zero),
    .aluCtr(aluCtr), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcEn(pcEn),
    .pcSource(pcSource), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .illegal(illegal), .instCount(instCount), .state(state)
  );

  // {state, aluCtr, aluSrcA, aluSrcB, pcEn, pcSource, iorD, memRead, memWrite,
  //  irWrite, regDst, memToReg, regWrite, illegal}
  typedef logic [21:0] obs_t;
  typedef struct {
    obs_t       o;
    logic [3:0] cnt;
    string      tag;
  } exp_t;

  obs_t       obs;
  exp_t       sb[$];
  logic [3:0] exp_cnt;
  int         tests = 0;
  int         fails = 0;

  assign obs = {state, aluCtr, aluSrcA, aluSrcB, pcEn, pcSource, iorD, memRead,
                memWrite, irWrite, regDst, memToReg, regWrite, illegal};

  // strb = {iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, illegal}
  function automatic obs_t mk(logic [3:0] st, logic [3:0] alu, logic a, logic [1:0] b,
                              logic pe, logic [1:0] ps, logic [7:0] strb);
    return {st, alu, a, b, pe, ps, strb};
  endfunction

  localparam obs_t E_FETCH    = {4'd0, 4'b0010, 1'b0, 2'b01, 1'b1, 2'b00, 8'b0101_0000};
  localparam obs_t E_FETCH_RS = {4'd0, 4'b0010, 1'b0, 2'b01, 1'b0, 2'b00, 8'b0000_0000};
  localparam obs_t E_DECODE   = {4'd1, 4'b0010, 1'b0, 2'b11, 1'b0, 2'b00, 8'b0000_0000};

  task automatic push(obs_t o, string tag);
    exp_t e;
    e.o = o; e.cnt = exp_cnt; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_next();
    exp_t e;
    @(negedge clk);
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty obs=%h exp=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.o) else begin
        fails++;
        $error("FAIL %s outputs obs=%h exp=%h", e.tag, obs, e.o);
      end
      tests++;
      assert (instCount === e.cnt) else begin
        fails++;
        $error("FAIL %s instCount obs=%0d exp=%0d", e.tag, instCount, e.cnt);
      end
    end
    tick();
  endtask

  // Queue the full per-cycle expectation of one instruction, then walk it.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z, logic [3:0] r_alu, string tag);
    int n;
    opCode = op; funct = fn; zero = z;
    push(E_FETCH, {tag, ".fetch"});
    push((op == 6'b111111) ? (E_DECODE | obs_t'(1)) : E_DECODE, {tag, ".decode"});
    case (op)
      6'b100011: begin
        push(mk(4'd2, 4'b0010, 1, 2'b10, 0, 2'b00, 8'b0000_0000), {tag, ".maddr"});
        push(mk(4'd3, 4'b0000, 0, 2'b00, 0, 2'b00, 8'b1100_0000), {tag, ".mrd"});
        push(mk(4'd4, 4'b0000, 0, 2'b00, 0, 2'b00, 8'b0000_0110), {tag, ".mwb"});
      end
      6'b101011: begin
        push(mk(4'd2, 4'b0010, 1, 2'b10, 0, 2'b00, 8'b0000_0000), {tag, ".maddr"});
        push(mk(4'd5, 4'b0000, 0, 2'b00, 0, 2'b00, 8'b1010_0000), {tag, ".mwr"});
      end
      6'b000000: begin
        if (r_alu == 4'b1111)
          push(mk(4'd6, 4'b1111, 1, 2'b00, 0, 2'b00, 8'b0000_0001), {tag, ".exec"});
        else begin
          push(mk(4'd6, r_alu, 1, 2'b00, 0, 2'b00, 8'b0000_0000), {tag, ".exec"});
          push(mk(4'd7, 4'b0000, 0, 2'b00, 0, 2'b00, 8'b0000_1010), {tag, ".rwb"});
        end
      end
      6'b000100: push(mk(4'd8, 4'b0110, 1, 2'b00, z, 2'b01, 8'b0000_0000), {tag, ".branch"});
      6'b000010: push(mk(4'd9, 4'b0000, 0, 2'b00, 1, 2'b10, 8'b0000_0000), {tag, ".jump"});
      6'b001000: begin
        push(mk(4'd10, 4'b0010, 1, 2'b10, 0, 2'b00, 8'b0000_0000), {tag, ".addi_ex"});
        push(mk(4'd11, 4'b0000, 0, 2'b00, 0, 2'b00, 8'b0000_0010), {tag, ".addi_wb"});
      end
      default: ;
    endcase
    n = sb.size();
    for (int i = 0; i < n; i++) check_next();
    exp_cnt = exp_cnt + 4'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opCode = 6'b111111; funct = 6'b0; zero = 1'b0;
    exp_cnt = 4'd0;
    tick();
    for (int i = 0; i < 3; i++) begin
      push(E_FETCH_RS, "reset_hold");
      check_next();
    end
    reset = 1'b0;

    run_instr(6'b000000, 6'b100010, 0, 4'b0110, "r_sub");
    run_instr(6'b000000, 6'b100000, 0, 4'b0010, "r_add");
    run_instr(6'b000000, 6'b100100, 0, 4'b0000, "r_and");
    run_instr(6'b000000, 6'b100101, 0, 4'b0001, "r_or");
    run_instr(6'b000000, 6'b101010, 0, 4'b0111, "r_slt");
    run_instr(6'b000000, 6'b100111, 1, 4'b1100, "r_nor");
    run_instr(6'b100011, 6'b000000, 0, 4'b0000, "lw");
    run_instr(6'b101011, 6'b111111, 1, 4'b0000, "sw");
    run_instr(6'b000100, 6'b000000, 1, 4'b0000, "beq_taken");
    run_instr(6'b000100, 6'b000000, 0, 4'b0000, "beq_not");
    run_instr(6'b111111, 6'b100000, 0, 4'b0000, "bad_op");
    run_instr(6'b000000, 6'b000000, 0, 4'b1111, "bad_funct");
    run_instr(6'b001000, 6'b000000, 0, 4'b0000, "addi");

    while (exp_cnt != 4'd15) run_instr(6'b000010, 6'b0, 0, 4'b0000, "j_fill");
    run_instr(6'b000010, 6'b0, 0, 4'b0000, "j_wrap0");
    run_instr(6'b000010, 6'b0, 0, 4'b0000, "j_wrap1");

    // lw aborted by reset while in MEM_RD
    opCode = 6'b100011; funct = 6'b0; zero = 1'b0;
    push(E_FETCH, "abort.fetch");
    push(E_DECODE, "abort.decode");
    push(mk(4'd2, 4'b0010, 1, 2'b10, 0, 2'b00, 8'b0000_0000), "abort.maddr");
    for (int i = 0; i < 3; i++) check_next();
    reset = 1'b1;
    push(mk(4'd3, 4'b0000, 0, 2'b00, 0, 2'b00, 8'b1000_0000), "abort.mrd_rst");
    check_next();
    exp_cnt = 4'd0;
    push(E_FETCH_RS, "abort.fetch_rst");
    check_next();
    reset = 1'b0;
    run_instr(6'b100011, 6'b0, 0, 4'b0000, "lw_after_rst");
    run_instr(6'b000010, 6'b0, 0, 4'b0000, "j_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control unit that drives the existing ALU and datapath of the lab05 MIPS core. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and emits the 4-bit `aluCtr` code, operand selects and write strobes the ALU and datapath consume. It also takes back the ALU `zero` flag to resolve `beq`. It replaces the single-cycle main control plus ALU-control pair.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `opCode`  in  6  instruction register [31:26]; stable from DECODE onward.
- `funct`  in  6  instruction register [5:0].
- `zero`  in  1  ALU zero flag.
- `aluCtr`  out  4  ALU operation code.
- `aluSrcA`  out  1  0 = PC, 1 = register A.
- `aluSrcB`  out  2  00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `pcEn`  out  1  PC load enable.
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `iorD`, `memRead`, `memWrite`, `irWrite`  out  1 each  memory/IR controls.
- `regDst`, `memToReg`, `regWrite`  out  1 each  register-file controls.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `instCount`  out  CNT_W  retired-instruction count.
- `state`  out  4  current state, for debug.

## Operation
- aluCtr codes: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, NOR 1100.
- funct decode (R-type EXECUTE): 100000→ADD, 100010→SUB, 100100→AND, 100101→OR, 101010→SLT, 100111→NOR. Any other funct gives 1111.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States, with outputs that are Moore functions of state. Unlisted strobes are 0; unlisted selects are 0/00.
  - FETCH: memRead, irWrite, pcEn; aluSrcB=01, aluCtr=ADD, pcSource=00. Next state DECODE.
  - DECODE: aluSrcB=11, aluCtr=ADD. Next state by opcode: lw/sw→MEM_ADDR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDI_EX. Any other opcode pulses `illegal` and returns to FETCH.
  - MEM_ADDR: aluSrcA=1, aluSrcB=10, aluCtr=ADD. lw→MEM_RD, sw→MEM_WR.
  - MEM_RD: iorD, memRead. Next state MEM_WB.
  - MEM_WB: regWrite, memToReg, regDst=0. Next state FETCH.
  - MEM_WR: iorD, memWrite. Next state FETCH.
  - EXEC: aluSrcA=1, aluSrcB=00, aluCtr=decoded funct. Next state R_WB. On an unsupported funct, pulse `illegal` and go to FETCH.
  - R_WB: regWrite, regDst=1. Next state FETCH.
  - BRANCH: aluSrcA=1, aluSrcB=00, aluCtr=SUB, pcSource=01, pcEn=`zero`. Next state FETCH.
  - JUMP: pcSource=10, pcEn. Next state FETCH.
  - ADDI_EX: aluSrcA=1, aluSrcB=10, aluCtr=ADD. Next state ADDI_WB.
  - ADDI_WB: regWrite, regDst=0. Next state FETCH.
- `instCount` increments by 1 on every transition into FETCH from a completing state. It also increments on an illegal abort. It wraps from 2^CNT_W−1 to 0.

## Timing
- Cycles per instruction: lw 5, sw 4, R 4, addi 4, beq 3, j 3. An illegal instruction takes 2 (or 3 for a bad funct).
- While `reset`=1, all strobes are forced to 0 combinationally: pcEn, irWrite, memRead, memWrite, regWrite, illegal.
- On the clock edge with `reset`=1, the state register loads FETCH and `instCount` loads 0.
- First cycle after reset: FETCH outputs. aluCtr=0010, aluSrcB=01, all other selects 0.
- Reset mid-instruction aborts it with no write strobe issued. The aborted instruction is not counted.
- `zero` is used only in BRANCH, in the same cycle it is produced. There is no registering.
- `opCode` and `funct` are ignored in FETCH.

## Structure
- Shared package `mips_ctrl_pkg` holds: opcode and funct constants, aluCtr constants, aluSrcB and pcSource encodings, and the state encoding (4-bit, FETCH=0).
- Sub-module `alu_ctr_decode` is combinational: funct→{aluCtr, valid}. It is reused later by the pipelined core.

## Test plan
- Reset held 3 cycles then released → all strobes 0 during reset; FETCH with aluCtr=0010, pcEn=1 on the first free cycle; instCount=0.
- R-type funct=100010 → state sequence FETCH, DECODE, EXEC (aluCtr=0110, aluSrcA=1), R_WB (regWrite=1, regDst=1); instCount+1 after 4 cycles.
- lw then sw → lw takes 5 cycles with memToReg=1 in MEM_WB; sw takes 4 cycles with memWrite=1 and iorD=1 in MEM_WR; regWrite is never asserted for sw.
- beq with zero=1, then beq with zero=0 → BRANCH shows aluCtr=0110 and pcSource=01; pcEn=1 for the first and 0 for the second.
- opCode=111111, then R-type funct=000000 → `illegal` pulses in DECODE and in EXEC respectively; no write strobe; return to FETCH; instCount increments for each.
- Preload instCount near 2^CNT_W−1 (CNT_W=4 build) and run 2 j instructions → count 15→0→1; reset asserted in MEM_RD → next state FETCH, regWrite never asserted.
